// File: rtl/leak_pkg.sv
// Shared definitions for the two-share masked-byte link: frame layout,
// receiver state encoding and the Hamming-weight helper.
package leak_pkg;

  localparam int FRAME_LEN  = 3;
  localparam int TAG_HW_MSB = 3;

  typedef enum logic [1:0] {
    GET_S0  = 2'd0,
    GET_S1  = 2'd1,
    GET_TAG = 2'd2,
    OUT     = 2'd3
  } state_t;

  function automatic logic [3:0] hw8(input logic [7:0] b);
    logic [3:0] acc;
    acc = 4'd0;
    for (int i = 0; i < 8; i++) begin
      acc = acc + {3'd0, b[i]};
    end
    return acc;
  endfunction

endpackage

// File: rtl/share_recombiner_if.sv
// Byte-stream input and recovered-frame output handshakes of the recombiner.
interface share_recombiner_if;
  import leak_pkg::*;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic [3:0] out_hw;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_hw, out_err, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_hw, out_err, out_valid
  );

endinterface

// File: rtl/share_recombiner_popcount8.sv
// Combinational 8-bit population count, result 0..8.
module popcount8
  import leak_pkg::*;
(
  input  logic [7:0] data,
  output logic [3:0] count
);

  assign count = hw8(data);

endmodule

// File: rtl/share_recombiner.sv
// Recombines (share0, share1, tag) frames into the unmasked byte, checks the tag
// against its Hamming weight and hands the result downstream with counters.
module share_recombiner
  import leak_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter bit CHECK_UPPER = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  share_recombiner_if.slave bus,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state_q, state_d;
  logic [7:0] share0_q;
  logic [7:0] d_q;
  logic [3:0] hw_q;
  logic [7:0] d_w;
  logic [3:0] hw_w;
  logic [7:0] out_data_q;
  logic [3:0] out_hw_q;
  logic       out_err_q;
  logic       tag_err;
  logic       in_xfer;
  logic       out_xfer;

  assign bus.in_ready  = (state_q != OUT);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = out_data_q;
  assign bus.out_hw    = out_hw_q;
  assign bus.out_err   = out_err_q;

  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

  assign d_w = share0_q ^ bus.in_data;

  popcount8 u_popcount8 (
    .data  (d_w),
    .count (hw_w)
  );

  assign tag_err = (bus.in_data[TAG_HW_MSB:0] != hw_q) |
                   (CHECK_UPPER & (bus.in_data[7:TAG_HW_MSB+1] != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= GET_S0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GET_S0:  if (in_xfer)  state_d = GET_S1;
      GET_S1:  if (in_xfer)  state_d = GET_TAG;
      GET_TAG: if (in_xfer)  state_d = OUT;
      OUT:     if (out_xfer) state_d = GET_S0;
      default:               state_d = GET_S0;
    endcase
  end

  // Recovered byte and its weight are captured on share1 so the tag check only
  // compares against registers when the tag arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      share0_q   <= '0;
      d_q        <= '0;
      hw_q       <= '0;
      out_data_q <= '0;
      out_hw_q   <= '0;
      out_err_q  <= 1'b0;
    end else if (in_xfer) begin
      case (state_q)
        GET_S0:  share0_q <= bus.in_data;
        GET_S1: begin
          d_q  <= d_w;
          hw_q <= hw_w;
        end
        GET_TAG: begin
          out_data_q <= d_q;
          out_hw_q   <= hw_q;
          out_err_q  <= tag_err;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= '0;
      err_count   <= '0;
    end else if (out_xfer) begin
      if (frame_count != CNT_MAX) frame_count <= frame_count + 1'b1;
      if (out_err_q && (err_count != CNT_MAX)) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_share_recombiner.sv
// Directed bench: three recombiner variants (default, upper nibble ignored,
// 2-bit counters) driven in lockstep with hand-computed expectations.
module tb_share_recombiner;
  import leak_pkg::*;

  logic clk;
  logic rst_n;
  logic [7:0] in_data;
  logic in_valid;
  logic out_ready;

  logic [15:0] fc_main, ec_main, fc_nu, ec_nu;
  logic [1:0]  fc_sat, ec_sat;

  int compared = 0;
  int mismatched = 0;

  share_recombiner_if if_main ();
  share_recombiner_if if_nu ();
  share_recombiner_if if_sat ();

  assign if_main.in_data = in_data;
  assign if_main.in_valid = in_valid;
  assign if_main.out_ready = out_ready;
  assign if_nu.in_data = in_data;
  assign if_nu.in_valid = in_valid;
  assign if_nu.out_ready = out_ready;
  assign if_sat.in_data = in_data;
  assign if_sat.in_valid = in_valid;
  assign if_sat.out_ready = out_ready;

  share_recombiner #(.CNT_W(16), .CHECK_UPPER(1'b1)) dut_main (
    .clk(clk), .rst_n(rst_n), .bus(if_main), .frame_count(fc_main), .err_count(ec_main));
  share_recombiner #(.CNT_W(16), .CHECK_UPPER(1'b0)) dut_nu (
    .clk(clk), .rst_n(rst_n), .bus(if_nu), .frame_count(fc_nu), .err_count(ec_nu));
  share_recombiner #(.CNT_W(2), .CHECK_UPPER(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(if_sat), .frame_count(fc_sat), .err_count(ec_sat));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int cnt;
    in_data = b;
    in_valid = 1'b1;
    cnt = 0;
    while (!if_main.in_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    if (cnt >= 50) checkOutput("in_ready_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] tg);
    applyStimulus(s0);
    applyStimulus(s1);
    applyStimulus(tg);
  endtask

  task automatic pulseReset();
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_data = 8'h00;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #12 rst_n = 1'b1;
    tick();

    checkOutput("rst_in_ready", if_main.in_ready, 1);
    checkOutput("rst_out_valid", if_main.out_valid, 0);
    checkOutput("rst_out_data", if_main.out_data, 0);
    checkOutput("rst_out_hw", if_main.out_hw, 0);
    checkOutput("rst_out_err", if_main.out_err, 0);
    checkOutput("rst_frame_count", fc_main, 0);
    checkOutput("rst_err_count", ec_main, 0);

    // Basic frame
    sendFrame(8'hA5, 8'h0F, 8'h04);
    checkOutput("basic_valid", if_main.out_valid, 1);
    checkOutput("basic_in_ready", if_main.in_ready, 0);
    checkOutput("basic_data", if_main.out_data, 8'hAA);
    checkOutput("basic_hw", if_main.out_hw, 4);
    checkOutput("basic_err", if_main.out_err, 0);
    tick();
    checkOutput("basic_valid_drop", if_main.out_valid, 0);
    checkOutput("basic_hold_data", if_main.out_data, 8'hAA);
    checkOutput("basic_fc", fc_main, 1);
    checkOutput("basic_ec", ec_main, 0);

    // Tag mismatch on lower nibble
    sendFrame(8'h00, 8'hFF, 8'h07);
    checkOutput("mis_data", if_main.out_data, 8'hFF);
    checkOutput("mis_hw", if_main.out_hw, 8);
    checkOutput("mis_err", if_main.out_err, 1);
    checkOutput("mis_err_nu", if_nu.out_err, 1);
    tick();
    checkOutput("mis_fc", fc_main, 2);
    checkOutput("mis_ec", ec_main, 1);

    // Correct weight but nonzero upper nibble
    sendFrame(8'h00, 8'hFF, 8'h18);
    checkOutput("upper_err_chk", if_main.out_err, 1);
    checkOutput("upper_err_nochk", if_nu.out_err, 0);
    tick();
    checkOutput("upper_ec_chk", ec_main, 2);
    checkOutput("upper_ec_nochk", ec_nu, 1);
    checkOutput("upper_fc", fc_main, 3);

    // Backpressure with a new frame waiting
    out_ready = 1'b0;
    sendFrame(8'h3C, 8'h3C, 8'h00);
    in_data = 8'h81;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", if_main.out_valid, 1);
      checkOutput("bp_data", if_main.out_data, 8'h00);
      checkOutput("bp_hw", if_main.out_hw, 0);
      checkOutput("bp_in_ready", if_main.in_ready, 0);
      tick();
    end
    checkOutput("bp_fc_held", fc_main, 3);
    out_ready = 1'b1;
    tick();
    checkOutput("bp_release_valid", if_main.out_valid, 0);
    checkOutput("bp_release_fc", fc_main, 4);
    checkOutput("bp_release_in_ready", if_main.in_ready, 1);

    // Bubbles between bytes; 81 is taken by the edge after this point
    applyStimulus(8'h81);
    repeat (3) tick();
    checkOutput("bub_in_ready", if_main.in_ready, 1);
    checkOutput("bub_no_valid", if_main.out_valid, 0);
    applyStimulus(8'h01);
    repeat (3) tick();
    checkOutput("bub_no_valid2", if_main.out_valid, 0);
    applyStimulus(8'h01);
    checkOutput("bub_valid", if_main.out_valid, 1);
    checkOutput("bub_data", if_main.out_data, 8'h80);
    checkOutput("bub_hw", if_main.out_hw, 1);
    checkOutput("bub_err", if_main.out_err, 0);
    tick();
    checkOutput("bub_fc", fc_main, 5);

    // Reset in the middle of a frame
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    pulseReset();
    tick();
    checkOutput("rmid_fc", fc_main, 0);
    checkOutput("rmid_valid", if_main.out_valid, 0);
    sendFrame(8'h55, 8'h55, 8'h00);
    checkOutput("rmid_data", if_main.out_data, 8'h00);
    checkOutput("rmid_hw", if_main.out_hw, 0);
    checkOutput("rmid_err", if_main.out_err, 0);
    tick();
    checkOutput("rmid_fc_after", fc_main, 1);
    checkOutput("rmid_ec_after", ec_main, 0);

    // Reset while a frame is held: dropped and uncounted
    out_ready = 1'b0;
    sendFrame(8'h01, 8'h02, 8'h02);
    checkOutput("rout_valid", if_main.out_valid, 1);
    pulseReset();
    out_ready = 1'b1;
    tick();
    checkOutput("rout_valid_drop", if_main.out_valid, 0);
    checkOutput("rout_fc", fc_main, 0);

    // Saturation on 2-bit counters, every tag wrong (d=01, hw=1, tag=00)
    for (int n = 1; n <= 5; n++) begin
      sendFrame(8'h01, 8'h00, 8'h00);
      checkOutput("sat_err", if_sat.out_err, 1);
      tick();
      checkOutput("sat_fc", fc_sat, (n > 3) ? 3 : n);
      checkOutput("sat_ec", ec_sat, (n > 3) ? 3 : n);
      checkOutput("sat_main_fc", fc_main, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
